// File: rtl/timer_pkg.sv
// Shared definitions for the shared delay timer and the sequencers that use it.
package timer_pkg;

    localparam int CNT_W_DEFAULT = 25;
    // Sequencers derive their len values from the system clock rate.
    localparam int CLK_HZ        = 27_000_000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last winner, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_win
);

    always_comb begin
        automatic int w_idx = 0;
        o_valid = 1'b0;
        o_win   = '0;
        // k=NUM_REQ revisits the last winner, so a lone requester can be re-served.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last) + k) % NUM_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_valid = 1'b1;
                o_win   = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One delay counter shared round-robin among NUM_REQ requesters with a req/done handshake.
module shared_timer_arbiter
    import timer_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] len,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         remaining
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_win;
    // Doubles as the remaining output: it is cleared whenever the FSM leaves RUN.
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;

    logic               w_valid;
    logic [IDX_W-1:0]   w_win;
    logic [CNT_W-1:0]   w_len;
    logic [CNT_W-1:0]   w_load;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .i_req  (req),
        .i_last (r_last),
        .o_valid(w_valid),
        .o_win  (w_win)
    );

    assign w_len  = len[int'(w_win)*CNT_W +: CNT_W];
    assign w_load = (w_len == '0) ? CNT_W'(1) : w_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_win   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_state <= S_RUN;
                        r_win   <= w_win;
                        r_last  <= w_win;
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_cnt   <= w_load;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A drop on the final count cycle is still an abort.
                    if (!req[r_win]) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= r_grant;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!req[r_win]) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_done  <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign remaining = r_cnt;

endmodule

// File: tb/tb_shared_timer_arbiter.sv
// Directed bench for shared_timer_arbiter: handshake timing, rotation, aborts, reset, wide count.
module tb_shared_timer_arbiter;

    localparam int N  = 3;
    localparam int CW = 25;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*CW-1:0] len;
    logic [N-1:0]    grant, done;
    logic            busy;
    logic [CW-1:0]   remaining;

    logic [N-1:0]    req8;
    logic [N*8-1:0]  len8;
    logic [N-1:0]    grant8, done8;
    logic            busy8;
    logic [7:0]      rem8;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    shared_timer_arbiter #(.NUM_REQ(N), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .len(len),
        .grant(grant), .done(done), .busy(busy), .remaining(remaining)
    );

    shared_timer_arbiter #(.NUM_REQ(N), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .len(len8),
        .grant(grant8), .done(done8), .busy(busy8), .remaining(rem8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prev;
        int t;
        int w;
        logic mono;

        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        req8  = '0;
        len8  = '0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_rem",   32'(remaining), 0);
        rst_n = 1'b1;
        tick();

        // single request, len=5
        len[0*CW +: CW] = 25'd5;
        req = 3'b001;
        tick();
        chk("t1_grant", 32'(grant), 1);
        chk("t1_busy",  32'(busy), 1);
        chk("t1_rem5",  32'(remaining), 5);
        repeat (4) tick();
        chk("t1_nodone", 32'(done), 0);
        chk("t1_rem1",   32'(remaining), 1);
        tick();
        chk("t1_done",     32'(done), 1);
        chk("t1_grant_hd", 32'(grant), 1);
        chk("t1_rem0",     32'(remaining), 0);
        req = 3'b000;
        tick();
        chk("t1_grant_clr", 32'(grant), 0);
        chk("t1_done_clr",  32'(done), 0);
        chk("t1_busy_clr",  32'(busy), 0);

        // round-robin rotation, all len=2, each winner drops on done
        do_reset();
        len  = {25'd2, 25'd2, 25'd2};
        req  = 3'b111;
        prev = 0;
        for (int s = 0; s < 6; s++) begin
            w = s % N;
            t = 0;
            while (grant == 0 && t < 10) begin
                tick();
                t++;
            end
            chk("rr_grant", 32'(grant), 32'(1) << w);
            if (s > 0) chk("rr_space", 32'(cyc - prev), 5);
            prev = cyc;
            tick();
            tick();
            chk("rr_done", 32'(done), 32'(1) << w);
            tick();
            req[w] = 1'b0;
            tick();
            req[w] = 1'b1;
        end
        req = 3'b000;
        tick();
        chk("rr_idle", 32'(busy), 0);

        // len=0 must behave exactly like len=1
        for (int lv = 0; lv < 2; lv++) begin
            len[1*CW +: CW] = CW'(lv);
            req = 3'b010;
            tick();
            chk("l0_grant", 32'(grant), 2);
            chk("l0_rem",   32'(remaining), 1);
            tick();
            chk("l0_done",  32'(done), 2);
            req = 3'b000;
            tick();
            chk("l0_clr",   32'(grant), 0);
        end

        // abort of requester 2; pointer must move on to requester 0
        len[2*CW +: CW] = 25'd10;
        len[0*CW +: CW] = 25'd9;
        req = 3'b101;
        tick();
        chk("ab_grant", 32'(grant), 4);
        chk("ab_rem10", 32'(remaining), 10);
        repeat (3) tick();
        chk("ab_rem7",  32'(remaining), 7);
        req = 3'b001;
        tick();
        chk("ab_grant_clr", 32'(grant), 0);
        chk("ab_nodone",    32'(done), 0);
        chk("ab_busy",      32'(busy), 0);
        tick();
        chk("ab_next0", 32'(grant), 1);
        chk("ab_rem9",  32'(remaining), 9);

        // asynchronous reset mid-RUN with remaining=7
        tick();
        tick();
        chk("ar_rem7", 32'(remaining), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 0);
        chk("ar_busy",  32'(busy), 0);
        chk("ar_rem",   32'(remaining), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_regrant", 32'(grant), 1);
        chk("ar_reload",  32'(remaining), 9);
        req = 3'b000;
        tick();
        chk("ar_abort", 32'(busy), 0);

        // full-scale count on the 8-bit build
        len8[0 +: 8] = 8'd255;
        req8 = 3'b001;
        tick();
        chk("w_grant", 32'(grant8), 1);
        chk("w_rem",   32'(rem8), 255);
        mono = 1'b1;
        for (int i = 1; i < 255; i++) begin
            tick();
            if (rem8 != 8'(255 - i) || done8 != 0) mono = 1'b0;
        end
        chk("w_mono",   32'(mono), 1);
        chk("w_rem1",   32'(rem8), 1);
        tick();
        chk("w_done",   32'(done8), 1);
        req8 = 3'b000;
        tick();
        chk("w_clr",    32'(grant8), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
